// File: rtl/mac_stream_arbiter.sv
// rtl/mac_stream_arbiter.sv - round-robin packet arbiter sharing one staged MAC between requesters
module mac_stream_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NUM_REQ*2*DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NUM_REQ-1:0]              S_AXIS_TVALID,
    input  logic [NUM_REQ-1:0]              S_AXIS_TLAST,
    input  logic [NUM_REQ-1:0]              S_AXIS_TUSER,
    output logic [NUM_REQ-1:0]              S_AXIS_TREADY,
    output logic [2*DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    output logic                            M_AXIS_TUSER,
    output logic [ID_WIDTH-1:0]             M_AXIS_TID,
    input  logic                            M_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0]           R_AXIS_TDATA,
    input  logic                            R_AXIS_TVALID,
    input  logic                            R_AXIS_TLAST,
    input  logic [ID_WIDTH-1:0]             R_AXIS_TID,
    output logic                            R_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]           O_AXIS_TDATA,
    output logic [NUM_REQ-1:0]              O_AXIS_TVALID,
    output logic                            O_AXIS_TLAST,
    input  logic [NUM_REQ-1:0]              O_AXIS_TREADY,
    output logic                            ERR_BAD_TID
);
    localparam int BEAT_W = 2 * DATA_WIDTH;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0]    MAX_OUT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ID_WIDTH-1:0] NUM_REQ_ID = ID_WIDTH'(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] grant_idx, grant_idx_next;
    logic [IDX_W-1:0] last_ptr, last_ptr_next;
    logic [CNT_W-1:0] outstanding;
    logic             err_bad_tid;

    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             pkt_done;
    logic             res_done;
    logic             tid_ok;
    logic [IDX_W-1:0] res_idx;

    // Round-robin search: first valid requester after the last-granted one
    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_ptr) + k) % NUM_REQ);
            if (!pick_valid && S_AXIS_TVALID[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Forward path: the granted channel passes straight through to the MAC
    always_comb begin
        M_AXIS_TDATA  = '0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TUSER  = 1'b0;
        M_AXIS_TVALID = 1'b0;
        S_AXIS_TREADY = '0;
        M_AXIS_TID    = ID_WIDTH'(grant_idx);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                M_AXIS_TDATA = S_AXIS_TDATA[i*BEAT_W +: BEAT_W];
                M_AXIS_TLAST = S_AXIS_TLAST[i];
                M_AXIS_TUSER = S_AXIS_TUSER[i];
                if (state == GRANT) begin
                    M_AXIS_TVALID    = S_AXIS_TVALID[i];
                    S_AXIS_TREADY[i] = M_AXIS_TREADY;
                end
            end
        end
    end

    assign tid_ok       = (R_AXIS_TID < NUM_REQ_ID);
    assign res_idx      = R_AXIS_TID[IDX_W-1:0];
    assign O_AXIS_TDATA = R_AXIS_TDATA;
    assign O_AXIS_TLAST = R_AXIS_TLAST;

    // Result path: steer by TID; out-of-range TIDs are swallowed
    always_comb begin
        O_AXIS_TVALID = '0;
        R_AXIS_TREADY = 1'b1;
        if (tid_ok) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (res_idx == IDX_W'(i)) begin
                    O_AXIS_TVALID[i] = R_AXIS_TVALID;
                    R_AXIS_TREADY    = O_AXIS_TREADY[i];
                end
            end
        end
    end

    assign pkt_done = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;
    assign res_done = R_AXIS_TVALID & R_AXIS_TREADY & R_AXIS_TLAST;

    // Next state: grant only with MAC credit, release on the final beat
    always_comb begin
        state_next     = state;
        grant_idx_next = grant_idx;
        last_ptr_next  = last_ptr;
        case (state)
            IDLE: begin
                if (pick_valid && (outstanding < MAX_OUT)) begin
                    state_next     = GRANT;
                    grant_idx_next = pick_idx;
                    last_ptr_next  = pick_idx;
                end
            end
            GRANT: begin
                if (pkt_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; requester 0 wins the first arbitration after reset
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            grant_idx <= '0;
            last_ptr  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state     <= state_next;
            grant_idx <= grant_idx_next;
            last_ptr  <= last_ptr_next;
        end
    end

    // Packets inside the MAC; a simultaneous send and return cancel out
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            outstanding <= '0;
        end else begin
            case ({pkt_done, res_done})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Sticky flag for results carrying a TID no requester owns
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            err_bad_tid <= 1'b0;
        end else if (R_AXIS_TVALID && !tid_ok) begin
            err_bad_tid <= 1'b1;
        end
    end

    assign ERR_BAD_TID = err_bad_tid;
endmodule
